prng_draw_ctrl: RTL
===================

// Module: prng_draw_ctrl
// PURPOSE
//  Sequences the 4-bit PRNG (SCLR/LOAD/EN/SEED -> PRN) and shares its output among NREQ requesters.
//  Per draw: round-robin grant, one PRNG step, one-cycle delivery of the new value.
//  Reseeds periodically (seed += SEED_STEP) and recovers the PRNG from the all-zero lock state.
//  Sits between the pulse-counter consumers and the single PRNG instance.
// PARAMETERS
//  NREQ            4   number of requesters (2..8)
//  RESEED_INTERVAL 16  successful draws between automatic reseeds; 0 = never reseed
//  SEED_STEP       3   added (mod 16) to the seed register on every reseed/zero recovery
// PORTS
//  SYS_CLK    in  1     system clock, rising edge
//  SYS_RST_N  in  1     asynchronous active-low reset
//  START      in  1     pulse: latch SEED_IN, clear+load PRNG, begin serving (HALT only)
//  STOP       in  1     level: return to HALT at next IDLE
//  SEED_IN    in  4     initial seed; 4'h0 is replaced by 4'h1
//  REQ        in  NREQ  draw requests, level, one bit per requester
//  GNT        out NREQ  one-hot grant, high exactly in the RND_VALID cycle
//  RND_OUT    out 4     delivered random value
//  RND_VALID  out 1     RND_OUT valid, single-cycle pulse
//  BUSY       out 1     high in every state except HALT
//  PRNG_SCLR  out 1     to PRNG SCLR
//  PRNG_LOAD  out 1     to PRNG LOAD
//  PRNG_EN    out 1     to PRNG EN
//  PRNG_SEED  out 4     to PRNG SEED (= seed register)
//  PRNG_PRN   in  4     from PRNG PRN. Updates at the edge ending a cycle with EN/LOAD/SCLR high.
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation):
//  - State HALT. PRNG_SCLR=1; all other outputs 0.
//  - Seed register 0, draw counter 0, RR pointer NREQ-1 (index 0 wins first).
//  States; all outputs registered, decoded from the state:
//  - HALT: PRNG_SCLR=1. START -> CLR; seed_reg <= (SEED_IN==0) ? 1 : SEED_IN.
//  - CLR: PRNG_SCLR=1 for one cycle -> LOAD.
//  - LOAD: PRNG_LOAD=1, PRNG_SEED=seed_reg for one cycle -> IDLE.
//  - IDLE: if STOP -> HALT (STOP has priority over REQ). Else if |REQ -> STEP.
//    On entering STEP, latch the winner: first set REQ bit after the pointer, searching upward with wrap.
//  - STEP: PRNG_EN=1 for one cycle -> DELIVER.
//  - DELIVER: RND_OUT=PRNG_PRN. Then:
//    - PRNG_PRN!=0: RND_VALID=1, GNT=onehot(winner), pointer<=winner, draw_cnt++.
//      If draw_cnt reaches RESEED_INTERVAL: draw_cnt<=0, seed_reg+=SEED_STEP, -> CLR. Else -> IDLE.
//    - PRNG_PRN==0 (lock): RND_VALID=0, GNT=0, pointer and draw_cnt unchanged.
//      seed_reg+=SEED_STEP, -> CLR; winner kept and re-served after LOAD (IDLE -> STEP, winner not re-arbitrated).
//  - Any seed update yielding 0 is forced to 1.
//  Latency: REQ seen in IDLE at edge k -> GNT/RND_VALID high in cycle k+2..k+3.
//  - Back-to-back draws every 3 cycles. Reseed adds 2 cycles (CLR, LOAD).
//  - REQ drop after winner latch does not cancel the grant. REQ change during STEP/DELIVER affects only the next arbitration.
//  - START outside HALT ignored. STOP during STEP/DELIVER/CLR/LOAD completes the current draw/load first.
//  - RND_OUT holds last delivered value while RND_VALID=0.
//  - Never more than one of PRNG_SCLR/PRNG_LOAD/PRNG_EN high in a cycle.
// TESTING (bench instantiates PRNG + scoreboard model)
//  1. Reset, START with SEED_IN=4'h5, REQ=4'b0001 held
//     -> PRNG_SCLR 1 cycle, then PRNG_LOAD with SEED=5.
//     -> GNT=0001 every 3 cycles, RND_OUT matches model.
//  2. REQ=4'b1111 held
//     -> GNT sequence 0001,0010,0100,1000,0001; every RND_OUT nonzero.
//  3. RESEED_INTERVAL=16, SEED 5
//     -> after 16th RND_VALID: CLR, then LOAD with PRNG_SEED=8.
//     -> after the next 16: PRNG_SEED=11; next GNT 5 cycles after the reseeding draw.
//  4. SEED_IN=4'h0, then force PRNG_PRN=0 in DELIVER
//     -> PRNG_SEED=1 on first load; on forced zero no RND_VALID, reload with seed 4.
//     -> same requester granted next.
//  5. STOP asserted in STEP
//     -> draw delivered, then HALT, BUSY=0, PRNG_SCLR=1.
//     -> START with SEED_IN=4'hD re-enters CLR/LOAD with seed 13.
//  6. SYS_RST_N low during DELIVER
//     -> GNT/RND_VALID drop immediately, PRNG_SCLR=1.
//     -> after release: HALT until START; first grant goes to index 0.

Source files
------------

// File: rtl/prng_draw_ctrl.sv
// prng_draw_ctrl: round-robin sharing of one 4-bit PRNG among NREQ requesters with periodic reseed and zero-lock recovery
module prng_draw_ctrl #(
  parameter int NREQ = 4,
  parameter int RESEED_INTERVAL = 16,
  parameter int SEED_STEP = 3
) (
  input  logic            SYS_CLK,
  input  logic            SYS_RST_N,
  input  logic            START,
  input  logic            STOP,
  input  logic [3:0]      SEED_IN,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [3:0]      RND_OUT,
  output logic            RND_VALID,
  output logic            BUSY,
  output logic            PRNG_SCLR,
  output logic            PRNG_LOAD,
  output logic            PRNG_EN,
  output logic [3:0]      PRNG_SEED,
  input  logic [3:0]      PRNG_PRN
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = RESEED_INTERVAL > 0 ? $clog2(RESEED_INTERVAL + 1) : 1;
  typedef enum logic [2:0] {HALT, CLR, LOAD, IDLE, STEP, DELIVER} state_t;
  state_t state;
  logic [3:0] seed_reg, seed_sum, seed_nxt;
  logic [CW-1:0] draw_cnt, cnt_inc;
  logic [IW-1:0] ptr, winner, arb, idx;
  logic hold, found, reseed_due;
  assign seed_sum = seed_reg + 4'(SEED_STEP);
  assign seed_nxt = (seed_sum == 4'h0) ? 4'h1 : seed_sum;
  assign cnt_inc = draw_cnt + CW'(1);
  assign reseed_due = (RESEED_INTERVAL != 0) && (cnt_inc == CW'(RESEED_INTERVAL));
  assign PRNG_SCLR = (state == HALT) || (state == CLR);
  assign PRNG_LOAD = state == LOAD;
  assign PRNG_EN = state == STEP;
  assign PRNG_SEED = seed_reg;
  assign BUSY = state != HALT;
  always_comb begin
    arb = ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && REQ[idx]) begin
        arb = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N)
    if (!SYS_RST_N) begin
      state <= HALT;
      seed_reg <= '0;
      draw_cnt <= '0;
      ptr <= IW'(NREQ - 1);
      winner <= '0;
      hold <= 1'b0;
      GNT <= '0;
      RND_OUT <= '0;
      RND_VALID <= 1'b0;
    end else begin
      GNT <= '0;
      RND_VALID <= 1'b0;
      case (state)
        HALT: if (START) begin
          state <= CLR;
          seed_reg <= (SEED_IN == 4'h0) ? 4'h1 : SEED_IN;
        end
        CLR: state <= LOAD;
        LOAD: state <= IDLE;
        IDLE: if (STOP) begin
          state <= HALT;
          hold <= 1'b0;
        end else if (hold || |REQ) begin
          state <= STEP;
          winner <= hold ? winner : arb;
        end
        STEP: state <= DELIVER;
        DELIVER: if (PRNG_PRN != 4'h0) begin
          RND_OUT <= PRNG_PRN;
          RND_VALID <= 1'b1;
          GNT <= NREQ'(1) << winner;
          ptr <= winner;
          hold <= 1'b0;
          draw_cnt <= reseed_due ? '0 : cnt_inc;
          seed_reg <= reseed_due ? seed_nxt : seed_reg;
          state <= reseed_due ? CLR : IDLE;
        end else begin
          hold <= 1'b1;
          seed_reg <= seed_nxt;
          state <= CLR;
        end
        default: state <= HALT;
      endcase
    end
endmodule
